// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualifier and USB core reset sequencer
//
// Purpose: synchronises the PLL lock flag, holds the USB core in reset until
// lock has been stable for LOCK_CYCLES and then HOLD_CYCLES more cycles, and
// releases a registered active-low core reset. A filtered loss of lock while
// running re-asserts the core reset and bumps a saturating drop counter.
//
// Ports:
//   clk        - PLL output clock, the only clock
//   rstn       - synchronous active-low reset, highest priority
//   lock       - PLL lock flag, asynchronous to clk
//   restart    - single-cycle request to re-run the sequence (not a drop)
//   core_rstn  - registered active-low reset to the USB core
//   state      - current state: WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3
//   drop_count - lock-loss events seen in RUN, saturates at 255
module pll_reset_sequencer #(
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int DROP_FILTER = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       lock,
    input  logic       restart,
    output logic       core_rstn,
    output logic [1:0] state,
    output logic [7:0] drop_count
);

    localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam int DCNT_W     = ($clog2(DROP_FILTER) < 1) ? 1 : $clog2(DROP_FILTER);

    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DROP_LAST = DCNT_W'(DROP_FILTER - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              lock_s_q, lock_s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic              core_rstn_q, core_rstn_d;

    always_comb begin
        sync1_d      = lock;
        lock_s_d     = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        dcnt_d       = dcnt_q;
        drop_count_d = drop_count_q;
        core_rstn_d  = core_rstn_q;

        if (restart) begin
            // Restart wins over a coincident drop, so drop_count is untouched.
            state_d     = WAIT_LOCK;
            cnt_d       = '0;
            dcnt_d      = '0;
            core_rstn_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    core_rstn_d = 1'b0;
                    if (lock_s_q) begin
                        state_d = STABILIZE;
                        cnt_d   = '0;
                    end
                end
                STABILIZE: begin
                    core_rstn_d = 1'b0;
                    if (!lock_s_q) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    core_rstn_d = 1'b0;
                    if (!lock_s_q) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d     = RUN;
                        core_rstn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // Only DROP_FILTER consecutive low samples count as a loss;
                    // any high sample clears the filter.
                    if (lock_s_q) begin
                        dcnt_d = '0;
                    end else if (dcnt_q == DROP_LAST) begin
                        state_d     = WAIT_LOCK;
                        core_rstn_d = 1'b0;
                        dcnt_d      = '0;
                        if (drop_count_q != 8'hFF) begin
                            drop_count_d = drop_count_q + 8'd1;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = WAIT_LOCK;
                    core_rstn_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            dcnt_q       <= '0;
            drop_count_q <= 8'd0;
            core_rstn_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            lock_s_q     <= lock_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dcnt_q       <= dcnt_d;
            drop_count_q <= drop_count_d;
            core_rstn_q  <= core_rstn_d;
        end
    end

    assign core_rstn  = core_rstn_q;
    assign state      = state_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sits directly downstream of the iCE40 PLL wrapper and runs in the 60 MHz PLL output domain. It synchronises the PLL `lock` flag and holds the USB core in reset until lock has been stable for a programmable time. It then releases a clean, synchronous active-low reset to the USB core. Loss of lock while running re-asserts the core reset and increments a sticky saturating drop counter, which is available for debug.

## Interface

Parameters:
- `LOCK_CYCLES`, default 1024: consecutive synchronised-lock-high cycles required in STABILIZE; must be ≥1.
- `HOLD_CYCLES`, default 16: extra cycles the core reset stays asserted after stabilisation; must be ≥1.
- `DROP_FILTER`, default 4: consecutive synchronised-lock-low cycles in RUN that count as lock loss; must be ≥1. Shorter glitches are ignored.

Ports:
- `clk`, in, 1: PLL global clock output (60 MHz); the only clock.
- `rstn`, in, 1: synchronous, active-low reset; highest priority.
- `lock`, in, 1: PLL lock flag, asynchronous to `clk`.
- `restart`, in, 1: single-cycle request to re-run the sequence; does not count as a drop.
- `core_rstn`, out, 1: registered, active-low reset to the USB core.
- `state`, out, 2: current state, encoded WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3.
- `drop_count`, out, 8: number of lock-loss events detected in RUN; saturates at 255.

## Operation

- `lock` passes through a 2-flop synchroniser (`sync1` → `lock_s`). All decisions use `lock_s` only.
- A single cycle counter `cnt` is shared by STABILIZE and HOLD. Its width is `$clog2(max(LOCK_CYCLES,HOLD_CYCLES))`, with a minimum of 1.
- A separate drop-filter counter `dcnt` has width `$clog2(DROP_FILTER)`, with a minimum of 1.
- Priority at every edge is `rstn` low, then `restart`, then normal transitions.
- When `rstn` is low, the edge sets: sync flops 0, state WAIT_LOCK, `cnt` 0, `dcnt` 0, `drop_count` 0, `core_rstn` 0.
- When `restart` is 1: state becomes WAIT_LOCK, `cnt` and `dcnt` become 0, `core_rstn` becomes 0, and `drop_count` is unchanged.
- WAIT_LOCK: if `lock_s`=1, go to STABILIZE with `cnt`←0; otherwise stay.
- STABILIZE:
  - `lock_s`=0: go to WAIT_LOCK, no filtering.
  - `lock_s`=1 and `cnt`==LOCK_CYCLES-1: go to HOLD with `cnt`←0.
  - `lock_s`=1 otherwise: `cnt`++.
- HOLD:
  - `lock_s`=0: go to WAIT_LOCK.
  - `cnt`==HOLD_CYCLES-1: go to RUN with `core_rstn`←1.
  - otherwise: `cnt`++.
- RUN:
  - `lock_s`=1: `dcnt`←0.
  - `lock_s`=0 and `dcnt`==DROP_FILTER-1: go to WAIT_LOCK, `core_rstn`←0, `dcnt`←0, and `drop_count`←`drop_count`+1 unless it is already 255.
  - `lock_s`=0 otherwise: `dcnt`++.
- `core_rstn` is a register. It is 1 only while in RUN, and it changes on the same edge as the corresponding state change.
- `restart` in RUN coinciding with a qualifying drop: `restart` wins, so `drop_count` is not incremented.

## Timing

- Reset values: `core_rstn`=0, `state`=0, `drop_count`=0.
- Let edge E0 be the first edge at which `sync1` samples `lock`=1, with `lock` held high afterwards. Then:
  - `lock_s` goes high after edge E0+1.
  - STABILIZE is entered at edge E0+2.
  - HOLD is entered at edge E0+2+LOCK_CYCLES.
  - RUN is entered and `core_rstn` rises at edge E0+2+LOCK_CYCLES+HOLD_CYCLES.
- Lock-loss latency in RUN: `core_rstn` falls at the edge that samples the DROP_FILTER-th consecutive `lock_s`=0. That is 2+DROP_FILTER-1 edges after the first edge at which `sync1` samples `lock`=0.
- `restart` latency: `core_rstn`=0 and `state`=0 take effect from the edge that samples `restart`.
- If `lock_s`=1 while in WAIT_LOCK after a restart, the block enters STABILIZE on the very next edge.
- `rstn` asserted mid-sequence: the next edge performs a full reset and clears `drop_count`.

## Test plan

Parameters for all scenarios: LOCK_CYCLES=4, HOLD_CYCLES=2, DROP_FILTER=3.

- Power-up: hold `rstn`=0 for 3 cycles, then `lock`=1 from E0 → `state` goes 0→1 at E0+2, 1→2 at E0+6, 2→3 at E0+8; `core_rstn` rises at E0+8; `drop_count`=0.
- Glitch tolerance: in RUN, drive `lock` low for 2 cycles → `core_rstn` stays 1, `state`=3, `drop_count`=0.
- Lock loss: in RUN, drive `lock` low for 3 or more cycles → `core_rstn` falls at the third `lock_s`-low edge, `state`=0, `drop_count`=1. Raise `lock` again → `core_rstn` rises 8 edges after `sync1` first samples 1.
- Early loss: drop `lock` for 1 cycle during STABILIZE → `state` returns to 0 with no filtering, and the full 4+2 sequence restarts when lock returns.
- `restart` with `lock` steady: pulse `restart` in RUN → `core_rstn`=0 at that edge, `state` goes 0→1 on the next edge, `core_rstn` rises 7 edges after the restart edge, and `drop_count` is unchanged. `restart` coinciding with a qualifying drop → no increment.
- Saturation and reset: force 256 lock-loss events → `drop_count` stays at 255. Then assert `rstn`=0 for 1 cycle → `drop_count`=0, `state`=0, `core_rstn`=0.
